// File: rtl/stepper_ramp_gen.sv
// Trapezoidal step-rate generator feeding the stepper phase sequencer.
// A move command (count + direction) produces one-cycle step pulses whose
// spacing ramps from START_PERIOD down to MIN_PERIOD, cruises, then ramps
// back up so the motor starts and stops without stalling.
module stepper_ramp_gen #(
    parameter int STEP_W       = 16,
    parameter int PERIOD_W     = 24,
    parameter int START_PERIOD = 200000,
    parameter int MIN_PERIOD   = 50000,
    parameter int ACCEL_DEC    = 1000
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              dir_in,
    input  logic [STEP_W-1:0] nsteps,
    input  logic              abort,
    output logic              step_pulse,
    output logic              dir,
    output logic              busy,
    output logic              done,
    output logic [STEP_W-1:0] steps_left
);

    typedef enum logic [2:0] {
        IDLE,
        ACCEL,
        CRUISE,
        DECEL,
        DONE
    } state_t;

    // Period constants, plus one-bit-wider copies so ramp arithmetic can
    // overshoot before being clamped instead of wrapping.
    localparam logic [PERIOD_W-1:0] START_P = PERIOD_W'(START_PERIOD);
    localparam logic [PERIOD_W-1:0] MIN_P   = PERIOD_W'(MIN_PERIOD);
    localparam logic [PERIOD_W-1:0] ONE_P   = PERIOD_W'(1);
    localparam logic [PERIOD_W:0]   START_X = (PERIOD_W+1)'(START_PERIOD);
    localparam logic [PERIOD_W:0]   MIN_X   = (PERIOD_W+1)'(MIN_PERIOD);
    localparam logic [PERIOD_W:0]   DEC_X   = (PERIOD_W+1)'(ACCEL_DEC);
    localparam logic [STEP_W-1:0]   ONE_S   = STEP_W'(1);

    state_t              state_q, state_d;
    logic [PERIOD_W-1:0] period_q, period_d;
    logic [PERIOD_W-1:0] timer_q, timer_d;
    logic [STEP_W-1:0]   ramp_cnt_q, ramp_cnt_d;
    logic [STEP_W-1:0]   steps_left_q, steps_left_d;
    logic                dir_q, dir_d;
    logic                busy_q, busy_d;
    logic                step_pulse_q, step_pulse_d;
    logic                done_q, done_d;

    logic [STEP_W-1:0]   rem;
    logic [PERIOD_W:0]   period_up;
    logic [PERIOD_W:0]   period_dn;
    logic [PERIOD_W-1:0] period_fast;

    // State register; reset parks the generator idle at the start-of-move rate.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            period_q     <= START_P;
            timer_q      <= '0;
            ramp_cnt_q   <= '0;
            steps_left_q <= '0;
            dir_q        <= 1'b0;
            busy_q       <= 1'b0;
            step_pulse_q <= 1'b0;
            done_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            period_q     <= period_d;
            timer_q      <= timer_d;
            ramp_cnt_q   <= ramp_cnt_d;
            steps_left_q <= steps_left_d;
            dir_q        <= dir_d;
            busy_q       <= busy_d;
            step_pulse_q <= step_pulse_d;
            done_q       <= done_d;
        end
    end

    // Command accept, interval timing and the accel/cruise/decel decision made at each step.
    always_comb begin
        state_d      = state_q;
        period_d     = period_q;
        timer_d      = timer_q;
        ramp_cnt_d   = ramp_cnt_q;
        steps_left_d = steps_left_q;
        dir_d        = dir_q;
        busy_d       = busy_q;
        step_pulse_d = 1'b0;
        done_d       = 1'b0;

        rem         = steps_left_q - ONE_S;
        period_up   = {1'b0, period_q} + DEC_X;
        period_dn   = {1'b0, period_q} - DEC_X;
        period_fast = (period_dn[PERIOD_W] || (period_dn < MIN_X)) ? MIN_P
                                                                    : period_dn[PERIOD_W-1:0];

        case (state_q)
            IDLE: begin
                if (start && (nsteps != '0)) begin
                    dir_d        = dir_in;
                    steps_left_d = nsteps;
                    period_d     = START_P;
                    timer_d      = START_P;
                    ramp_cnt_d   = '0;
                    busy_d       = 1'b1;
                    state_d      = ACCEL;
                end
            end
            ACCEL, CRUISE, DECEL: begin
                if (abort) begin
                    state_d      = IDLE;
                    busy_d       = 1'b0;
                    steps_left_d = '0;
                end else if (timer_q != ONE_P) begin
                    timer_d = timer_q - ONE_P;
                end else begin
                    step_pulse_d = 1'b1;
                    steps_left_d = rem;
                    if (rem == '0) begin
                        state_d = DONE;
                    end else if ((state_q == DECEL) || (rem <= ramp_cnt_q)) begin
                        state_d    = DECEL;
                        period_d   = (period_up > START_X) ? START_P : period_up[PERIOD_W-1:0];
                        ramp_cnt_d = (ramp_cnt_q == '0) ? '0 : ramp_cnt_q - ONE_S;
                    end else if (period_q > MIN_P) begin
                        period_d   = period_fast;
                        ramp_cnt_d = ramp_cnt_q + ONE_S;
                        state_d    = (period_fast == MIN_P) ? CRUISE : ACCEL;
                    end else begin
                        state_d = CRUISE;
                    end
                    timer_d = period_d;
                end
            end
            DONE: begin
                done_d  = 1'b1;
                busy_d  = 1'b0;
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign step_pulse = step_pulse_q;
    assign dir        = dir_q;
    assign busy       = busy_q;
    assign done       = done_q;
    assign steps_left = steps_left_q;

endmodule

// File: tb/tb_stepper_ramp_gen.sv
// Bench for stepper_ramp_gen with small ramp constants. Each accepted move is
// expanded into its full list of expected pulse/done events; a monitor pops
// and compares them as the DUT produces them.
module tb_stepper_ramp_gen;

    localparam int STEP_W   = 16;
    localparam int PERIOD_W = 24;
    localparam int S        = 10;
    localparam int M        = 4;
    localparam int D        = 2;

    logic              clk = 1'b0;
    logic              rst;
    logic              start;
    logic              dir_in;
    logic [STEP_W-1:0] nsteps;
    logic              abort;
    logic              step_pulse;
    logic              dir;
    logic              busy;
    logic              done;
    logic [STEP_W-1:0] steps_left;

    typedef struct {
        bit is_done;
        int at;
        int sl;
        bit d;
    } exp_t;

    exp_t sb[$];
    int   pcyc[$];
    int   cyc   = 0;
    int   tests = 0;
    int   fails = 0;
    int   move_n;
    int   move_last;

    stepper_ramp_gen #(
        .STEP_W(STEP_W), .PERIOD_W(PERIOD_W),
        .START_PERIOD(S), .MIN_PERIOD(M), .ACCEL_DEC(D)
    ) dut (
        .clk(clk), .rst(rst), .start(start), .dir_in(dir_in), .nsteps(nsteps),
        .abort(abort), .step_pulse(step_pulse), .dir(dir), .busy(busy),
        .done(done), .steps_left(steps_left)
    );

    // Free-running clock and a cycle counter the expectations are timed against.
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("[TB] FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic nextCycle();
        @(posedge clk);
        #1;
    endtask

    // Step-level model of the ramp rules: the period chosen after each step
    // is the gap to the next pulse; the first pulse lands START+1 after accept.
    function automatic void buildSchedule(input int t, input int n, input bit d);
        int  p    = S;
        int  ramp = 0;
        bit  dec  = 0;
        int  tc   = t + S + 1;
        int  rem;
        pcyc.delete();
        for (int k = 1; k <= n; k++) begin
            sb.push_back('{0, tc, n - k, d});
            pcyc.push_back(tc);
            rem = n - k;
            if (rem == 0) begin
                sb.push_back('{1, tc + 1, 0, d});
                move_last = tc;
            end else begin
                if (dec || rem <= ramp) begin
                    dec  = 1;
                    p    = (p + D > S) ? S : p + D;
                    ramp = (ramp > 0) ? ramp - 1 : 0;
                end else if (p > M) begin
                    p    = (p - D < M) ? M : p - D;
                    ramp = ramp + 1;
                end
                tc = tc + p;
            end
        end
        move_n = n;
    endfunction

    function automatic int slAt(input int c);
        int issued = 0;
        foreach (pcyc[i]) if (pcyc[i] <= c) issued++;
        return move_n - issued;
    endfunction

    function automatic void purgeAfter(input int c);
        exp_t keep[$];
        foreach (sb[i]) if (sb[i].at <= c) keep.push_back(sb[i]);
        sb = keep;
    endfunction

    // Drive one start strobe in the current cycle; only an expected accept extends the scoreboard.
    task automatic applyStimulus(input int n, input bit d, input bit accept);
        start  = 1'b1;
        nsteps = STEP_W'(n);
        dir_in = d;
        if (accept) buildSchedule(cyc, n, d);
        nextCycle();
        start = 1'b0;
    endtask

    task automatic runToEnd();
        int guard = 0;
        while (cyc < move_last + 2 && guard < 2000) begin
            nextCycle();
            guard++;
        end
        checkOutput("queue_drained", sb.size(), 0);
        sb.delete();
    endtask

    // Raise abort during cycle a; it only takes effect while stepping (before the DONE cycle).
    task automatic abortAt(input int a, output bit effective);
        while (cyc < a) nextCycle();
        abort     = 1'b1;
        effective = (a < move_last);
        if (effective) purgeAfter(a);
        nextCycle();
        abort = 1'b0;
        if (effective) begin
            checkOutput("abort_busy", busy, 0);
            checkOutput("abort_steps_left", steps_left, 0);
            checkOutput("abort_no_pulse", step_pulse, 0);
        end
    endtask

    // Monitor: every pulse or done must match the oldest outstanding expectation.
    always @(negedge clk) begin
        exp_t e;
        if (step_pulse === 1'b1) begin
            if (sb.size() == 0) begin
                tests++;
                fails++;
                $display("[TB] FAIL unexpected_pulse: step_pulse=1 at cycle %0d, expected none", cyc);
            end else begin
                e = sb.pop_front();
                checkOutput("pulse_kind", 32'(e.is_done), 0);
                checkOutput("pulse_cycle", cyc, e.at);
                checkOutput("pulse_steps_left", steps_left, e.sl);
                checkOutput("pulse_dir", dir, e.d);
                checkOutput("pulse_busy", busy, 1);
            end
        end
        if (done === 1'b1) begin
            if (sb.size() == 0) begin
                tests++;
                fails++;
                $display("[TB] FAIL unexpected_done: done=1 at cycle %0d, expected none", cyc);
            end else begin
                e = sb.pop_front();
                checkOutput("done_kind", 32'(e.is_done), 1);
                checkOutput("done_cycle", cyc, e.at);
                checkOutput("done_busy", busy, 0);
                checkOutput("done_steps_left", steps_left, 0);
            end
        end
    end

    // Hard stop if something stalls the stimulus sequence.
    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: simulation time limit reached at cycle %0d, expected completion", cyc);
        $fatal(1, "[TB] watchdog expired");
    end

    // Directed scenarios followed by randomized moves with occasional aborts.
    initial begin
        bit eff;
        int t0;
        rst = 1'b1; start = 1'b0; dir_in = 1'b0; nsteps = '0; abort = 1'b0;
        nextCycle(); nextCycle(); nextCycle();
        checkOutput("reset_pulse", step_pulse, 0);
        checkOutput("reset_done", done, 0);
        checkOutput("reset_busy", busy, 0);
        checkOutput("reset_dir", dir, 0);
        checkOutput("reset_steps_left", steps_left, 0);
        rst = 1'b0;
        nextCycle();

        // Triangular move: 10, 8, 10
        applyStimulus(3, 1'b1, 1'b1);
        checkOutput("accept_busy", busy, 1);
        checkOutput("accept_steps_left", steps_left, 3);
        runToEnd();

        // Full trapezoid with an ignored start mid-move
        applyStimulus(10, 1'b0, 1'b1);
        t0 = cyc;
        while (cyc < t0 + 15) nextCycle();
        applyStimulus(5, 1'b1, 1'b0);
        checkOutput("ignored_start_dir", dir, 0);
        checkOutput("ignored_start_steps_left", steps_left, slAt(cyc));
        checkOutput("ignored_start_busy", busy, 1);
        runToEnd();

        // Zero-length command is ignored
        applyStimulus(0, 1'b1, 1'b0);
        checkOutput("zero_cmd_busy", busy, 0);
        nextCycle(); nextCycle();
        checkOutput("zero_cmd_busy_later", busy, 0);

        // Abort coincident with the cruise step event, restart one cycle later
        applyStimulus(10, 1'b1, 1'b1);
        abortAt(pcyc[4] - 1, eff);
        checkOutput("abort_drained", sb.size(), 0);
        applyStimulus(1, 1'b0, 1'b1);

        // Single step; a start in the DONE cycle is ignored, the next one accepted
        while (cyc < move_last) nextCycle();
        applyStimulus(2, 1'b1, 1'b0);
        checkOutput("done_cycle_start_ignored", busy, 0);
        applyStimulus(2, 1'b1, 1'b1);
        runToEnd();

        // Reset mid-move: silent for START+5 cycles afterwards
        applyStimulus(10, 1'b1, 1'b1);
        t0 = cyc;
        while (cyc < t0 + 25) nextCycle();
        rst = 1'b1;
        purgeAfter(cyc);
        nextCycle();
        checkOutput("midreset_busy", busy, 0);
        checkOutput("midreset_dir", dir, 0);
        checkOutput("midreset_steps_left", steps_left, 0);
        nextCycle(); nextCycle();
        rst = 1'b0;
        for (int i = 0; i < S + 5; i++) nextCycle();
        checkOutput("post_reset_busy", busy, 0);
        checkOutput("post_reset_drained", sb.size(), 0);
        sb.delete();

        // Randomized moves
        for (int i = 0; i < 16; i++) begin
            int gap = $urandom_range(0, 3);
            for (int g = 0; g < gap; g++) nextCycle();
            applyStimulus($urandom_range(1, 25), 1'($urandom_range(0, 1)), 1'b1);
            if ($urandom_range(0, 3) == 0) begin
                abortAt($urandom_range(move_last, cyc), eff);
                if (eff) begin
                    checkOutput("rand_abort_drained", sb.size(), 0);
                    sb.delete();
                end else begin
                    runToEnd();
                end
            end else begin
                runToEnd();
            end
        end

        nextCycle();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
